// File: rtl/timing_stats_if.sv
// Bus between the timing manager / software and the timing statistics block.
// The master side drives the acquisition events and read index; the slave side returns statistics.
interface timing_stats_if;
    logic        trigger;
    logic        sched_isr;
    logic [5:0]  en_bits;
    logic [15:0] eddy0_time;
    logic [15:0] eddy1_time;
    logic [15:0] eddy2_time;
    logic [15:0] eddy3_time;
    logic [15:0] encoder_time;
    logic [15:0] adc_time;
    logic        clear_stats;
    logic [2:0]  rd_sel;
    logic [15:0] rd_min;
    logic [15:0] rd_max;
    logic [15:0] rd_last;
    logic [5:0]  sample_valid;
    logic [31:0] cycle_count;
    logic [15:0] overrun_count;
    logic        busy;

    modport master (
        output trigger, sched_isr, en_bits,
        output eddy0_time, eddy1_time, eddy2_time, eddy3_time, encoder_time, adc_time,
        output clear_stats, rd_sel,
        input  rd_min, rd_max, rd_last, sample_valid, cycle_count, overrun_count, busy
    );

    modport slave (
        input  trigger, sched_isr, en_bits,
        input  eddy0_time, eddy1_time, eddy2_time, eddy3_time, encoder_time, adc_time,
        input  clear_stats, rd_sel,
        output rd_min, rd_max, rd_last, sample_valid, cycle_count, overrun_count, busy
    );
endinterface

// File: rtl/timing_stats.sv
// Per-sensor min/max/last acquisition-time statistics, updated one sensor per cycle
// through a single shared comparator pair after each scheduler completion pulse.
module timing_stats (
    input  logic           clk,
    input  logic           rst_n,
    timing_stats_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, ARMED, UPDATE} state_t;

    state_t      state;
    state_t      next_state;
    logic [2:0]  idx;
    logic        pending;
    logic [15:0] snap_time [6];
    logic [5:0]  snap_en;
    logic [15:0] min_r  [6];
    logic [15:0] max_r  [6];
    logic [15:0] last_r [6];
    logic [5:0]  valid_r;
    logic [31:0] cycle_r;
    logic [15:0] overrun_r;

    logic [15:0] in_time [6];
    logic [15:0] cur_time;
    logic [15:0] cur_min;
    logic [15:0] cur_max;
    logic        is_gt;
    logic        is_lt;
    logic        first;
    logic        last_idx;

    always_comb begin
        in_time[0] = bus.eddy0_time;
        in_time[1] = bus.eddy1_time;
        in_time[2] = bus.eddy2_time;
        in_time[3] = bus.eddy3_time;
        in_time[4] = bus.encoder_time;
        in_time[5] = bus.adc_time;
    end

    // One comparator pair shared by all sensors, steered by the update index.
    always_comb begin
        cur_time = snap_time[idx];
        cur_min  = min_r[idx];
        cur_max  = max_r[idx];
        is_gt    = cur_time > cur_max;
        is_lt    = cur_time < cur_min;
        first    = !valid_r[idx];
        last_idx = (idx == 3'd5);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (bus.trigger) next_state = ARMED;
            ARMED:   if (bus.sched_isr) next_state = UPDATE;
            UPDATE:  if (last_idx) next_state = (pending || bus.trigger) ? ARMED : IDLE;
            default: next_state = IDLE;
        endcase
        if (bus.clear_stats) begin
            next_state = IDLE;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx       <= 3'd0;
            pending   <= 1'b0;
            snap_en   <= 6'd0;
            valid_r   <= 6'd0;
            cycle_r   <= 32'd0;
            overrun_r <= 16'd0;
            for (int i = 0; i < 6; i++) begin
                snap_time[i] <= 16'd0;
                min_r[i]     <= 16'hFFFF;
                max_r[i]     <= 16'd0;
                last_r[i]    <= 16'd0;
            end
        end else if (bus.clear_stats) begin
            idx       <= 3'd0;
            pending   <= 1'b0;
            valid_r   <= 6'd0;
            cycle_r   <= 32'd0;
            overrun_r <= 16'd0;
            for (int i = 0; i < 6; i++) begin
                min_r[i]  <= 16'hFFFF;
                max_r[i]  <= 16'd0;
                last_r[i] <= 16'd0;
            end
        end else begin
            case (state)
                ARMED: begin
                    if (bus.sched_isr) begin
                        snap_en <= bus.en_bits;
                        idx     <= 3'd0;
                        for (int i = 0; i < 6; i++) begin
                            snap_time[i] <= in_time[i];
                        end
                        if (bus.trigger) pending <= 1'b1;
                    end else if (bus.trigger && overrun_r != 16'hFFFF) begin
                        overrun_r <= overrun_r + 16'd1;
                    end
                end
                UPDATE: begin
                    if (snap_en[idx]) begin
                        last_r[idx]  <= cur_time;
                        valid_r[idx] <= 1'b1;
                        if (first || is_gt) max_r[idx] <= cur_time;
                        if (first || is_lt) min_r[idx] <= cur_time;
                    end
                    if (bus.trigger) begin
                        if (pending) begin
                            if (overrun_r != 16'hFFFF) overrun_r <= overrun_r + 16'd1;
                        end else begin
                            pending <= 1'b1;
                        end
                    end
                    // Finishing the sweep consumes any pending trigger by re-arming.
                    if (last_idx) begin
                        idx     <= 3'd0;
                        pending <= 1'b0;
                        cycle_r <= cycle_r + 32'd1;
                    end else begin
                        idx <= idx + 3'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        bus.rd_min  = 16'd0;
        bus.rd_max  = 16'd0;
        bus.rd_last = 16'd0;
        if (bus.rd_sel < 3'd6) begin
            bus.rd_min  = min_r[bus.rd_sel];
            bus.rd_max  = max_r[bus.rd_sel];
            bus.rd_last = last_r[bus.rd_sel];
        end
    end

    assign bus.sample_valid  = valid_r;
    assign bus.cycle_count   = cycle_r;
    assign bus.overrun_count = overrun_r;
    assign bus.busy          = (state != IDLE);

endmodule

// File: tb/tb_timing_stats.sv
// Directed bench for timing_stats: a vector table of full acquisitions plus
// hand-written sequences for overrun, pending re-arm, clear and reset corners.
module tb_timing_stats;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    timing_stats_if bus();

    timing_stats dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [5:0]        en;
        logic [5:0][15:0]  t;
        logic [2:0]        sel;
        logic [15:0]       exp_min;
        logic [15:0]       exp_max;
        logic [15:0]       exp_last;
        logic [5:0]        exp_valid;
        logic [31:0]       exp_cycles;
    } vec_t;

    vec_t vecs [8];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic setTimes(input logic [5:0][15:0] t);
        bus.eddy0_time   = t[0];
        bus.eddy1_time   = t[1];
        bus.eddy2_time   = t[2];
        bus.eddy3_time   = t[3];
        bus.encoder_time = t[4];
        bus.adc_time     = t[5];
    endtask

    task automatic waitIdle();
        for (int n = 0; n < 20; n++) begin
            if (!bus.busy) break;
            step();
        end
        checkOutput("idle_timeout", {31'd0, bus.busy}, 32'd0);
    endtask

    task automatic applyStimulus(input logic [5:0] en, input logic [5:0][15:0] t);
        bus.en_bits = en;
        setTimes(t);
        bus.trigger = 1'b1;
        step();
        bus.trigger   = 1'b0;
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        waitIdle();
    endtask

    task automatic checkSel(input string name, input logic [2:0] sel,
                            input logic [15:0] mn, input logic [15:0] mx, input logic [15:0] ls);
        bus.rd_sel = sel;
        #1;
        checkOutput({name, "_min"},  {16'd0, bus.rd_min},  {16'd0, mn});
        checkOutput({name, "_max"},  {16'd0, bus.rd_max},  {16'd0, mx});
        checkOutput({name, "_last"}, {16'd0, bus.rd_last}, {16'd0, ls});
    endtask

    initial begin
        #5000000;
        $display("[TB] FAIL watchdog actual=running expected=finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        checks = 0;
        errors = 0;

        vecs[0] = '{6'h21, {16'd100, 16'd4, 16'd3, 16'd2, 16'd1, 16'd40}, 3'd5, 16'd100, 16'd100, 16'd100, 6'h21, 32'd1};
        vecs[1] = '{6'h20, {16'd80, 16'd4, 16'd3, 16'd2, 16'd1, 16'd999}, 3'd5, 16'd80, 16'd100, 16'd80, 6'h21, 32'd2};
        vecs[2] = '{6'h20, {16'd120, 16'd4, 16'd3, 16'd2, 16'd1, 16'd1}, 3'd5, 16'd80, 16'd120, 16'd120, 6'h21, 32'd3};
        vecs[3] = '{6'h01, {16'd5, 16'd4, 16'd3, 16'd2, 16'd1, 16'd30}, 3'd0, 16'd30, 16'd40, 16'd30, 6'h21, 32'd4};
        vecs[4] = '{6'h10, {16'd5, 16'hFFFF, 16'd3, 16'd2, 16'd1, 16'd6}, 3'd4, 16'hFFFF, 16'hFFFF, 16'hFFFF, 6'h31, 32'd5};
        vecs[5] = '{6'h10, {16'd5, 16'd0, 16'd3, 16'd2, 16'd1, 16'd6}, 3'd4, 16'd0, 16'hFFFF, 16'd0, 6'h31, 32'd6};
        vecs[6] = '{6'h00, {16'd77, 16'd77, 16'd77, 16'd77, 16'd77, 16'd77}, 3'd0, 16'd30, 16'd40, 16'd30, 6'h31, 32'd7};
        vecs[7] = '{6'h3F, {16'd50, 16'd50, 16'd50, 16'd50, 16'd50, 16'd50}, 3'd2, 16'd50, 16'd50, 16'd50, 6'h3F, 32'd8};

        bus.trigger     = 1'b0;
        bus.sched_isr   = 1'b0;
        bus.clear_stats = 1'b0;
        bus.en_bits     = 6'd0;
        bus.rd_sel      = 3'd0;
        setTimes('0);
        rst_n = 1'b0;
        repeat (3) step();

        checkOutput("reset_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("reset_cycles", bus.cycle_count, 32'd0);
        checkOutput("reset_overrun", {16'd0, bus.overrun_count}, 32'd0);
        checkOutput("reset_valid", {26'd0, bus.sample_valid}, 32'd0);
        checkSel("reset_sel0", 3'd0, 16'hFFFF, 16'd0, 16'd0);
        rst_n = 1'b1;
        step();

        // Scheduler pulse with nothing armed must be ignored.
        bus.en_bits = 6'h3F;
        setTimes({16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9});
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        step();
        checkOutput("idle_isr_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("idle_isr_cycles", bus.cycle_count, 32'd0);
        checkOutput("idle_isr_valid", {26'd0, bus.sample_valid}, 32'd0);

        for (int i = 0; i < 8; i++) begin
            applyStimulus(vecs[i].en, vecs[i].t);
            checkSel($sformatf("vec%0d", i), vecs[i].sel, vecs[i].exp_min, vecs[i].exp_max, vecs[i].exp_last);
            checkOutput($sformatf("vec%0d_valid", i), {26'd0, bus.sample_valid}, {26'd0, vecs[i].exp_valid});
            checkOutput($sformatf("vec%0d_cycles", i), bus.cycle_count, vecs[i].exp_cycles);
            checkSel($sformatf("vec%0d_sel7", i), 3'd7, 16'd0, 16'd0, 16'd0);
            if (i == 0) checkSel("vec0_sel0", 3'd0, 16'd40, 16'd40, 16'd40);
        end

        // Second trigger while armed counts as an overrun.
        bus.en_bits = 6'd0;
        bus.trigger = 1'b1;
        step();
        step();
        bus.trigger = 1'b0;
        checkOutput("overrun_one", {16'd0, bus.overrun_count}, 32'd1);
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        waitIdle();
        checkOutput("overrun_cycles", bus.cycle_count, 32'd9);

        // Trigger coincident with the scheduler pulse re-arms after the sweep.
        bus.trigger = 1'b1;
        step();
        bus.sched_isr = 1'b1;
        step();
        bus.trigger   = 1'b0;
        bus.sched_isr = 1'b0;
        repeat (6) step();
        checkOutput("rearm_busy", {31'd0, bus.busy}, 32'd1);
        checkOutput("rearm_cycles", bus.cycle_count, 32'd10);
        checkOutput("rearm_overrun", {16'd0, bus.overrun_count}, 32'd1);
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        waitIdle();
        checkOutput("rearm_done_cycles", bus.cycle_count, 32'd11);

        // Two triggers during the sweep: first pends, second overruns.
        bus.trigger = 1'b1;
        step();
        bus.trigger   = 1'b0;
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        bus.trigger   = 1'b1;
        step();
        step();
        bus.trigger = 1'b0;
        repeat (4) step();
        checkOutput("upd_overrun", {16'd0, bus.overrun_count}, 32'd2);
        checkOutput("upd_cycles", bus.cycle_count, 32'd12);
        checkOutput("upd_pending_busy", {31'd0, bus.busy}, 32'd1);
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        waitIdle();
        checkOutput("upd_done_cycles", bus.cycle_count, 32'd13);

        // Inputs changed during the sweep must not leak into the results.
        bus.en_bits = 6'h02;
        setTimes({16'd1, 16'd1, 16'd1, 16'd1, 16'd300, 16'd1});
        bus.trigger = 1'b1;
        step();
        bus.trigger   = 1'b0;
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        bus.en_bits   = 6'h3F;
        setTimes({16'd5, 16'd5, 16'd999, 16'd5, 16'd5, 16'd5});
        waitIdle();
        checkSel("snap_sel1", 3'd1, 16'd50, 16'd300, 16'd300);
        checkSel("snap_sel3", 3'd3, 16'd50, 16'd50, 16'd50);
        checkOutput("snap_cycles", bus.cycle_count, 32'd14);

        // Drive the overrun counter to saturation, then clear mid-sweep.
        bus.en_bits = 6'h20;
        setTimes({16'd7, 16'd7, 16'd7, 16'd7, 16'd7, 16'd7});
        bus.trigger = 1'b1;
        step();
        repeat (65533) step();
        checkOutput("sat_reach", {16'd0, bus.overrun_count}, 32'hFFFF);
        step();
        checkOutput("sat_hold", {16'd0, bus.overrun_count}, 32'hFFFF);
        bus.trigger   = 1'b0;
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        repeat (2) step();
        bus.clear_stats = 1'b1;
        bus.trigger     = 1'b1;
        step();
        bus.clear_stats = 1'b0;
        bus.trigger     = 1'b0;
        checkOutput("clear_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("clear_cycles", bus.cycle_count, 32'd0);
        checkOutput("clear_overrun", {16'd0, bus.overrun_count}, 32'd0);
        checkOutput("clear_valid", {26'd0, bus.sample_valid}, 32'd0);
        checkSel("clear_sel5", 3'd5, 16'hFFFF, 16'd0, 16'd0);
        step();
        checkOutput("clear_stays_idle", {31'd0, bus.busy}, 32'd0);

        // Asynchronous reset in the middle of a sweep, then the first trigger.
        bus.en_bits = 6'h3F;
        setTimes({16'd9, 16'd9, 16'd9, 16'd9, 16'd9, 16'd9});
        bus.trigger = 1'b1;
        step();
        bus.trigger   = 1'b0;
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        repeat (2) step();
        rst_n = 1'b0;
        #1;
        checkOutput("rst_mid_busy", {31'd0, bus.busy}, 32'd0);
        checkOutput("rst_mid_valid", {26'd0, bus.sample_valid}, 32'd0);
        checkSel("rst_mid_sel0", 3'd0, 16'hFFFF, 16'd0, 16'd0);
        step();
        rst_n = 1'b1;
        bus.trigger = 1'b1;
        step();
        bus.trigger = 1'b0;
        checkOutput("first_trig_busy", {31'd0, bus.busy}, 32'd1);
        bus.sched_isr = 1'b1;
        step();
        bus.sched_isr = 1'b0;
        waitIdle();
        checkOutput("first_trig_cycles", bus.cycle_count, 32'd1);
        checkSel("first_trig_sel0", 3'd0, 16'd9, 16'd9, 16'd9);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
